// File: rtl/ex_div_pkg.sv
// Shared constants and types for the execute-stage RV32M divide unit.
package ex_div_pkg;

    // RV32M instruction fields
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    // Restoring divider iteration count
    localparam int         DIV_ITER  = 32;
    localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

    // Common word/register constants
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  ZERO_REG      = 5'd0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        HOLD_ENABLE   = 1'b1;
    localparam logic        HOLD_DISABLE  = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // True for DIV/DIVU/REM/REMU
    function automatic logic is_div_inst(input logic [31:0] inst);
        logic [2:0] f3;
        f3 = inst[14:12];
        return (inst[6:0] == OPCODE_OP) && (inst[31:25] == FUNCT7_MULDIV) &&
               ((f3 == FUNCT3_DIV) || (f3 == FUNCT3_DIVU) ||
                (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU));
    endfunction

endpackage

// File: rtl/ex_div.sv
// Execute-stage RV32M divide unit: 32-iteration restoring divider with
// pipeline hold while busy and a one-cycle write-back strobe when done.
module ex_div
    import ex_div_pkg::*;
(
    input  logic        clk_100MHz,
    input  logic        arst_n,
    input  logic [31:0] inst_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        jump_ena_i,
    output logic        hold_req_o,
    output logic        busy_o,
    output logic [31:0] result_o,
    output logic        reg_w_ena_o,
    output logic [4:0]  reg_w_addr_o
);

    div_state_e state, state_next;

    // Decode of the instruction held in ID/EX
    logic [2:0]         funct3;
    logic               start;
    logic               op_signed;
    logic               op_rem;
    logic signed [31:0] op1_s;
    logic signed [31:0] op2_s;
    logic               op1_neg;
    logic               op2_neg;
    logic               div_by_zero;
    logic               div_overflow;
    logic               special;
    logic [31:0]        special_result;
    logic               unused_inst;

    // Iteration state
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic [4:0]  count_q;
    logic [4:0]  rd_q;
    logic        rem_sel_q;
    logic        neg_quot_q;
    logic        neg_rem_q;

    // One restoring step
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        rem_ge;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [31:0] final_result;

    // Two's-complement negate when requested; 0x80000000 maps onto itself
    function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    assign funct3       = inst_i[14:12];
    assign start        = is_div_inst(inst_i);
    assign op_signed    = (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    assign op_rem       = (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
    assign op1_s        = op1_i;
    assign op2_s        = op2_i;
    assign op1_neg      = op_signed && (op1_s < 0);
    assign op2_neg      = op_signed && (op2_s < 0);
    assign div_by_zero  = (op2_i == ZERO_WORD);
    assign div_overflow = op_signed && (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
    assign special      = div_by_zero || div_overflow;
    assign unused_inst  = ^{inst_i[24:15], inst_i[11:7]};

    always_comb begin
        special_result = ZERO_WORD;
        if (div_by_zero) begin
            special_result = op_rem ? op1_i : 32'hFFFF_FFFF;
        end else begin
            special_result = op_rem ? ZERO_WORD : 32'h8000_0000;
        end
    end

    // Remainder needs 33 bits before the compare: it can reach 2*divisor-1
    assign rem_shift    = {remainder_q, dividend_q[31]};
    assign rem_diff     = rem_shift - {1'b0, divisor_q};
    assign rem_ge       = (rem_shift >= {1'b0, divisor_q});
    assign rem_next     = rem_ge ? rem_diff[31:0] : rem_shift[31:0];
    assign quot_next    = {quotient_q[30:0], rem_ge};
    assign final_result = rem_sel_q ? apply_sign(rem_next, neg_rem_q)
                                    : apply_sign(quot_next, neg_quot_q);

    assign busy_o = (state != DIV_IDLE);

    // State register
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, hold request and write-back strobe
    always_comb begin
        state_next  = state;
        hold_req_o  = HOLD_DISABLE;
        reg_w_ena_o = WRITE_DISABLE;
        case (state)
            DIV_IDLE: begin
                if (start && !jump_ena_i) begin
                    hold_req_o = HOLD_ENABLE;
                    state_next = special ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                hold_req_o = HOLD_ENABLE;
                if (jump_ena_i) begin
                    state_next = DIV_IDLE;
                end else if (count_q == LAST_ITER) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                reg_w_ena_o = jump_ena_i ? WRITE_DISABLE : WRITE_ENABLE;
                state_next  = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // Operand latch, restoring iteration and registered result
    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            dividend_q   <= ZERO_WORD;
            divisor_q    <= ZERO_WORD;
            quotient_q   <= ZERO_WORD;
            remainder_q  <= ZERO_WORD;
            count_q      <= 5'd0;
            rd_q         <= ZERO_REG;
            rem_sel_q    <= 1'b0;
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            result_o     <= ZERO_WORD;
            reg_w_addr_o <= ZERO_REG;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && !jump_ena_i) begin
                        rd_q        <= reg_w_addr_i;
                        rem_sel_q   <= op_rem;
                        neg_quot_q  <= op1_neg ^ op2_neg;
                        neg_rem_q   <= op1_neg;
                        dividend_q  <= apply_sign(op1_i, op1_neg);
                        divisor_q   <= apply_sign(op2_i, op2_neg);
                        quotient_q  <= ZERO_WORD;
                        remainder_q <= ZERO_WORD;
                        count_q     <= 5'd0;
                        if (special) begin
                            result_o     <= special_result;
                            reg_w_addr_o <= reg_w_addr_i;
                        end
                    end
                end
                DIV_CALC: begin
                    if (!jump_ena_i) begin
                        dividend_q  <= {dividend_q[30:0], 1'b0};
                        quotient_q  <= quot_next;
                        remainder_q <= rem_next;
                        count_q     <= count_q + 5'd1;
                        if (count_q == LAST_ITER) begin
                            result_o     <= final_result;
                            reg_w_addr_o <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized
// operations against an arithmetic reference model.
module tb_ex_div;

    logic        clk;
    logic        arst_n;
    logic [31:0] inst_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        jump_ena_i;
    logic        hold_req_o;
    logic        busy_o;
    logic [31:0] result_o;
    logic        reg_w_ena_o;
    logic [4:0]  reg_w_addr_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result = 32'h0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ex_div dut (
        .clk_100MHz  (clk),
        .arst_n      (arst_n),
        .inst_i      (inst_i),
        .reg_w_addr_i(reg_w_addr_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .jump_ena_i  (jump_ena_i),
        .hold_req_o  (hold_req_o),
        .busy_o      (busy_o),
        .result_o    (result_o),
        .reg_w_ena_o (reg_w_ena_o),
        .reg_w_addr_o(reg_w_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // RISC-V M-extension semantics from plain arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic is_signed;
        logic want_rem;
        is_signed = (f3 == 3'b100) || (f3 == 3'b110);
        want_rem  = (f3 == 3'b110) || (f3 == 3'b111);
        sa = a;
        sb = b;
        if (b == 32'h0) return want_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return want_rem ? 32'h0 : 32'h8000_0000;
        if (is_signed) return want_rem ? 32'(sa % sb) : 32'(sa / sb);
        return want_rem ? (a % b) : (a / b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one divide, wait (bounded) for its write-back and check it
    task automatic do_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        int cycles;
        int holds;
        logic got;
        int exp_lat;
        logic [31:0] exp_res;
        exp_res = ref_result(f3, a, b);
        exp_lat = ((b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        @(posedge clk); #1;
        inst_i = mk_inst(7'b0000001, f3, rd);
        op1_i = a;
        op2_i = b;
        reg_w_addr_i = rd;
        #1;
        cycles = 0;
        holds = 0;
        got = 1'b0;
        while (!got && cycles < 60) begin
            if (hold_req_o) holds++;
            if (reg_w_ena_o) got = 1'b1;
            else begin
                @(posedge clk); #1;
                cycles++;
            end
        end
        check({tag, " wb_seen"}, {31'b0, got}, 32'd1);
        check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, " hold_cycles"}, 32'(holds), 32'(exp_lat));
        check({tag, " result"}, result_o, exp_res);
        check({tag, " rd"}, {27'b0, reg_w_addr_o}, {27'b0, rd});
        inst_i = NOP;
        @(posedge clk); #1;
        check({tag, " wb_one_cycle"}, {31'b0, reg_w_ena_o}, 32'd0);
        check({tag, " idle_after"}, {31'b0, busy_o}, 32'd0);
        check({tag, " result_held"}, result_o, exp_res);
        last_result = exp_res;
    endtask

    initial begin
        int ena_seen;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0] rd;
        int sel;

        arst_n = 1'b1;
        inst_i = NOP;
        reg_w_addr_i = 5'd0;
        op1_i = 32'h0;
        op2_i = 32'h0;
        jump_ena_i = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        check("rst result", result_o, 32'h0);
        check("rst wena", {31'b0, reg_w_ena_o}, 32'd0);
        check("rst waddr", {27'b0, reg_w_addr_o}, 32'd0);
        check("rst busy", {31'b0, busy_o}, 32'd0);
        check("rst hold_nop", {31'b0, hold_req_o}, 32'd0);
        inst_i = mk_inst(7'b0000001, 3'b101, 5'd3);
        #1;
        check("rst hold_start", {31'b0, hold_req_o}, 32'd1);
        inst_i = NOP;
        @(posedge clk); #1;
        arst_n = 1'b1;

        // Directed cases
        do_div(3'b101, 32'd100, 32'd7, 5'd5, "divu100_7");
        do_div(3'b111, 32'd100, 32'd7, 5'd6, "remu100_7");
        do_div(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, "div-7_2");
        do_div(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, "rem-7_2");
        do_div(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd9, "div7_-2");
        do_div(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd10, "rem7_-2");
        do_div(3'b101, 32'd5, 32'd0, 5'd11, "divu5_0");
        do_div(3'b111, 32'd5, 32'd0, 5'd12, "remu5_0");
        do_div(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd13, "rem-5_0");
        do_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "div_ovf");
        do_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "rem_ovf");
        do_div(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, "divu_big");
        do_div(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd17, "remu_big");

        // Flush in CALC: abort with no write-back, result keeps old value
        @(posedge clk); #1;
        inst_i = mk_inst(7'b0000001, 3'b101, 5'd20);
        op1_i = 32'd1000;
        op2_i = 32'd3;
        reg_w_addr_i = 5'd20;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        jump_ena_i = 1'b1;
        inst_i = NOP;
        #1;
        check("jmp calc wena", {31'b0, reg_w_ena_o}, 32'd0);
        @(posedge clk); #1;
        jump_ena_i = 1'b0;
        check("jmp idle busy", {31'b0, busy_o}, 32'd0);
        check("jmp idle hold", {31'b0, hold_req_o}, 32'd0);
        ena_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (reg_w_ena_o) ena_seen++;
        end
        check("jmp no_wb", 32'(ena_seen), 32'd0);
        check("jmp result_kept", result_o, last_result);

        // Flush in DONE suppresses the strobe
        @(posedge clk); #1;
        inst_i = mk_inst(7'b0000001, 3'b101, 5'd21);
        op1_i = 32'd5;
        op2_i = 32'd0;
        reg_w_addr_i = 5'd21;
        @(posedge clk); #1;
        inst_i = NOP;
        jump_ena_i = 1'b1;
        #1;
        check("jmp done busy", {31'b0, busy_o}, 32'd1);
        check("jmp done wena", {31'b0, reg_w_ena_o}, 32'd0);
        @(posedge clk); #1;
        jump_ena_i = 1'b0;
        check("jmp done idle", {31'b0, busy_o}, 32'd0);
        check("jmp done no_wb", {31'b0, reg_w_ena_o}, 32'd0);

        // Non-divide instructions never request a hold
        inst_i = mk_inst(7'b0000000, 3'b000, 5'd4);
        ena_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (hold_req_o || busy_o) ena_seen++;
        end
        check("add no_hold", 32'(ena_seen), 32'd0);
        inst_i = mk_inst(7'b0000001, 3'b000, 5'd4);
        ena_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (hold_req_o || busy_o) ena_seen++;
        end
        check("mul no_hold", 32'(ena_seen), 32'd0);
        inst_i = NOP;

        // Asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        inst_i = mk_inst(7'b0000001, 3'b101, 5'd22);
        op1_i = 32'd100;
        op2_i = 32'd7;
        reg_w_addr_i = 5'd22;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
        end
        #2;
        arst_n = 1'b0;
        inst_i = NOP;
        #1;
        check("arst result", result_o, 32'h0);
        check("arst wena", {31'b0, reg_w_ena_o}, 32'd0);
        check("arst waddr", {27'b0, reg_w_addr_o}, 32'd0);
        check("arst busy", {31'b0, busy_o}, 32'd0);
        check("arst hold", {31'b0, hold_req_o}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst_n = 1'b1;
        do_div(3'b101, 32'd9, 32'd3, 5'd23, "divu9_3");

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            f3 = {1'b1, 2'(sel)};
            rd = 5'($urandom_range(1, 31));
            sel = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (sel == 0) b = 32'h0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                a = 32'($urandom_range(0, 200));
                b = 32'($urandom_range(1, 15));
            end else if (sel == 3) b = 32'($urandom_range(1, 255));
            do_div(f3, a, b, rd, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
